// File: rtl/capped_accumulator_pkg.sv
// Shared definitions for the capped accumulator: command encodings and
// saturation-limit helpers used by the adder core.
package capped_pkg;

    // Widest accumulator the saturation helpers can describe.
    localparam int MAXW = 64;

    // Command opcodes carried on in_op.
    typedef enum logic [1:0] {
        OP_ACC   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_READ  = 2'b11
    } op_e;

    // Largest positive two's-complement value of a w-bit word (0x7F..F), zero-extended.
    function automatic logic [MAXW-1:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of a w-bit word (0x80..0), zero-extended.
    function automatic logic [MAXW-1:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/capped_accumulator_add_core.sv
// Combinational signed adder with an extra guard bit. Reports overflow in
// either direction and either clamps to the signed limits or wraps.
module capped_add_core
    import capped_pkg::*;
#(
    parameter int BITWIDTH = 32
) (
    input  logic [BITWIDTH-1:0] a,
    input  logic [BITWIDTH-1:0] b,
    input  logic                sat_en,
    output logic [BITWIDTH-1:0] sum,
    output logic                ovf
);

    localparam logic [BITWIDTH-1:0] MAX_V = BITWIDTH'(sat_max(BITWIDTH));
    localparam logic [BITWIDTH-1:0] MIN_V = BITWIDTH'(sat_min(BITWIDTH));

    logic [BITWIDTH:0] ext_sum_s;
    logic              pos_ovf_s;
    logic              neg_ovf_s;

    // Sign-extend both operands by one bit so the top two bits expose overflow.
    assign ext_sum_s = {a[BITWIDTH-1], a} + {b[BITWIDTH-1], b};
    assign pos_ovf_s = (ext_sum_s[BITWIDTH:BITWIDTH-1] == 2'b01);
    assign neg_ovf_s = (ext_sum_s[BITWIDTH:BITWIDTH-1] == 2'b10);

    // Select clamped or wrapped result; overflow is flagged in both modes.
    always_comb begin
        sum = ext_sum_s[BITWIDTH-1:0];
        ovf = pos_ovf_s | neg_ovf_s;
        if (sat_en && pos_ovf_s) begin
            sum = MAX_V;
        end else if (sat_en && neg_ovf_s) begin
            sum = MIN_V;
        end else begin
            sum = ext_sum_s[BITWIDTH-1:0];
        end
    end

endmodule

// File: rtl/capped_accumulator.sv
// Multi-channel signed accumulator. Each accepted command updates one
// channel and produces a registered result on a valid/ready port, with
// per-channel sticky overflow flags.
module capped_accumulator
    import capped_pkg::*;
#(
    parameter  int BITWIDTH = 32,
    parameter  int NCH      = 4,
    localparam int CHW      = $clog2(NCH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CHW-1:0]      in_ch,
    input  logic [1:0]          in_op,
    input  logic [BITWIDTH-1:0] in_data,
    input  logic                sat_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CHW-1:0]      out_ch,
    output logic [BITWIDTH-1:0] out_data,
    output logic                out_ovf,
    output logic                out_err,
    output logic [NCH-1:0]      sat_sticky,
    input  logic [NCH-1:0]      sticky_clr
);

    localparam logic [CHW:0] NCH_W = (CHW + 1)'(NCH);

    logic [BITWIDTH-1:0] acc_r [NCH];
    logic                out_valid_r;
    logic [CHW-1:0]      out_ch_r;
    logic [BITWIDTH-1:0] out_data_r;
    logic                out_ovf_r;
    logic                out_err_r;
    logic [NCH-1:0]      sticky_r;

    logic                accept_s;
    logic                legal_s;
    logic [BITWIDTH-1:0] cur_s;
    logic [BITWIDTH-1:0] add_sum_s;
    logic                add_ovf_s;
    logic [BITWIDTH-1:0] res_s;
    logic                res_ovf_s;
    logic                res_err_s;
    logic                we_s;
    logic [NCH-1:0]      sticky_set_s;

    // A new command may enter whenever the output slot is empty or draining this cycle.
    assign in_ready = !rst && (!out_valid_r || out_ready);
    assign accept_s = in_valid && in_ready;
    assign legal_s  = ({1'b0, in_ch} < NCH_W);

    assign out_valid  = out_valid_r;
    assign out_ch     = out_ch_r;
    assign out_data   = out_data_r;
    assign out_ovf    = out_ovf_r;
    assign out_err    = out_err_r;
    assign sat_sticky = sticky_r;

    // Read the addressed channel; illegal indices read as zero.
    always_comb begin
        cur_s = {BITWIDTH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            cur_s = (in_ch == CHW'(i)) ? acc_r[i] : cur_s;
        end
    end

    capped_add_core #(
        .BITWIDTH (BITWIDTH)
    ) u_add_core (
        .a      (cur_s),
        .b      (in_data),
        .sat_en (sat_en),
        .sum    (add_sum_s),
        .ovf    (add_ovf_s)
    );

    // Decode the command into the new channel value, write enable and status bits.
    always_comb begin
        res_s     = {BITWIDTH{1'b0}};
        res_ovf_s = 1'b0;
        res_err_s = 1'b0;
        we_s      = 1'b0;
        if (!legal_s) begin
            res_err_s = 1'b1;
        end else begin
            case (in_op)
                OP_ACC: begin
                    res_s     = add_sum_s;
                    res_ovf_s = add_ovf_s;
                    we_s      = 1'b1;
                end
                OP_LOAD: begin
                    res_s = in_data;
                    we_s  = 1'b1;
                end
                OP_CLEAR: begin
                    res_s = {BITWIDTH{1'b0}};
                    we_s  = 1'b1;
                end
                OP_READ: begin
                    res_s = cur_s;
                end
                default: begin
                    res_s = cur_s;
                end
            endcase
        end
    end

    // One-hot sticky set for the channel that overflowed on this accept.
    always_comb begin
        sticky_set_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            sticky_set_s[i] = accept_s && res_ovf_s && (in_ch == CHW'(i));
        end
    end

    // Channel register array: written on the accept edge of ACC/LOAD/CLEAR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                acc_r[i] <= {BITWIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (accept_s && we_s && (in_ch == CHW'(i))) begin
                    acc_r[i] <= res_s;
                end
            end
        end
    end

    // Output register stage: load on accept, empty on transfer, hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_ch_r    <= {CHW{1'b0}};
            out_data_r  <= {BITWIDTH{1'b0}};
            out_ovf_r   <= 1'b0;
            out_err_r   <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_ch_r    <= in_ch;
            out_data_r  <= res_s;
            out_ovf_r   <= res_ovf_s;
            out_err_r   <= res_err_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Sticky overflow flags: clear strobes apply first so a same-edge set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_r <= {NCH{1'b0}};
        end else begin
            sticky_r <= (sticky_r & ~sticky_clr) | sticky_set_s;
        end
    end

endmodule
